// File: rtl/scope_capture_ctrl.sv
// Decimating, trigger-armed single-frame capture buffer with a ready/done/hold handshake to the display.
// The read port is one cycle behind rd_addr. The block has no backpressure: samples arriving outside ARM/CAPTURE are dropped.
module scope_capture_ctrl #(
  parameter int FRAME_LEN = 160,
  parameter int SAMPLE_W  = 7,
  parameter int DECIM_W   = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                sample_valid,
  input  logic                sample_sign,
  input  logic [SAMPLE_W-1:0] sample_mag,
  input  logic [SAMPLE_W:0]   trig_level,
  input  logic                trig_slope,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                hold,
  input  logic                force_trig,
  input  logic                frame_done,
  input  logic [7:0]          rd_addr,
  output logic                rd_sign,
  output logic [SAMPLE_W-1:0] rd_mag,
  output logic                frame_ready,
  output logic                auto_trig,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    ST_ARM     = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_READY   = 2'b10,
    ST_HOLD    = 2'b11
  } state_e;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);
  localparam logic [7:0]    LAST_PTR  = 8'(FRAME_LEN - 1);

  state_e                     state_q, state_d;
  logic [DECIM_W-1:0]         dcnt_q, dcnt_d;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  logic signed [SAMPLE_W:0]   prev_q, prev_d;
  logic                       prev_valid_q, prev_valid_d;
  logic [7:0]                 wr_ptr_q, wr_ptr_d;
  logic                       frame_ready_q, frame_ready_d;
  logic                       auto_trig_q, auto_trig_d;
  logic                       rd_sign_q;
  logic [SAMPLE_W-1:0]        rd_mag_q;

  logic [SAMPLE_W:0]          mem [FRAME_LEN];
  logic                       buf_we;
  logic [7:0]                 buf_wa;

  logic signed [SAMPLE_W:0]   v;
  logic signed [SAMPLE_W:0]   lvl;
  logic                       kept;
  logic                       level_hit;
  logic                       timeout_hit;
  logic                       enter_arm;
  logic [TW-1:0]              tcnt_inc;

  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    tcnt_d        = tcnt_q;
    prev_d        = prev_q;
    prev_valid_d  = prev_valid_q;
    wr_ptr_d      = wr_ptr_q;
    frame_ready_d = frame_ready_q;
    auto_trig_d   = auto_trig_q;
    buf_we        = 1'b0;
    buf_wa        = wr_ptr_q;
    enter_arm     = 1'b0;
    level_hit     = 1'b0;
    timeout_hit   = 1'b0;
    tcnt_inc      = tcnt_q + 1'b1;

    // Negative zero folds to zero through the two's-complement negate.
    v    = sample_sign ? (~{1'b0, sample_mag} + 1'b1) : {1'b0, sample_mag};
    lvl  = trig_level;
    kept = sample_valid && (dcnt_q == '0);

    if (sample_valid) begin
      dcnt_d = (dcnt_q >= decim) ? '0 : dcnt_q + 1'b1;
    end

    unique case (state_q)
      ST_ARM: begin
        if (kept) begin
          level_hit = prev_valid_q &&
                      (trig_slope ? (prev_q > lvl && v <= lvl)
                                  : (prev_q < lvl && v >= lvl));
          timeout_hit  = (TIMEOUT != 0) && (tcnt_inc == TIMEOUT_C);
          prev_d       = v;
          prev_valid_d = 1'b1;
          if (TIMEOUT != 0) tcnt_d = tcnt_inc;
          if (level_hit || force_trig || timeout_hit) begin
            buf_we      = 1'b1;
            buf_wa      = 8'd0;
            wr_ptr_d    = 8'd1;
            state_d     = ST_CAPTURE;
            auto_trig_d = !(level_hit || force_trig);
          end
        end
      end
      ST_CAPTURE: begin
        if (kept) begin
          buf_we = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            state_d       = ST_READY;
            frame_ready_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 8'd1;
          end
        end
      end
      ST_READY: begin
        if (frame_done) begin
          if (hold) state_d = ST_HOLD;
          else      enter_arm = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!hold) enter_arm = 1'b1;
      end
      default: enter_arm = 1'b1;
    endcase

    // A strobe coincident with re-arming is decimation index 0, so it seeds prev.
    if (enter_arm) begin
      state_d       = ST_ARM;
      frame_ready_d = 1'b0;
      tcnt_d        = '0;
      prev_valid_d  = 1'b0;
      dcnt_d        = '0;
      if (sample_valid) begin
        dcnt_d       = (decim == '0) ? '0 : DECIM_W'(1);
        prev_d       = v;
        prev_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_ARM;
      dcnt_q        <= '0;
      tcnt_q        <= '0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      wr_ptr_q      <= '0;
      frame_ready_q <= 1'b0;
      auto_trig_q   <= 1'b0;
      rd_sign_q     <= 1'b0;
      rd_mag_q      <= '0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      tcnt_q        <= tcnt_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_ready_q <= frame_ready_d;
      auto_trig_q   <= auto_trig_d;
      if (int'(rd_addr) < FRAME_LEN) begin
        rd_sign_q <= mem[rd_addr][SAMPLE_W];
        rd_mag_q  <= mem[rd_addr][SAMPLE_W-1:0];
      end else begin
        rd_sign_q <= 1'b0;
        rd_mag_q  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_wa] <= {sample_sign, sample_mag};
  end

  assign rd_sign     = rd_sign_q;
  assign rd_mag      = rd_mag_q;
  assign frame_ready = frame_ready_q;
  assign auto_trig   = auto_trig_q;
  assign state       = state_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed bench for scope_capture_ctrl with a short auto-trigger timeout (8 kept samples).
module tb_scope_capture_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       sample_valid, sample_sign;
  logic [6:0] sample_mag;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic [15:0] decim;
  logic       hold, force_trig, frame_done;
  logic [7:0] rd_addr;
  logic       rd_sign;
  logic [6:0] rd_mag;
  logic       frame_ready, auto_trig;
  logic [1:0] state;

  int pass_cnt = 0;
  int total_cnt = 0;

  scope_capture_ctrl #(.FRAME_LEN(160), .SAMPLE_W(7), .DECIM_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .sample_valid(sample_valid), .sample_sign(sample_sign), .sample_mag(sample_mag),
    .trig_level(trig_level), .trig_slope(trig_slope), .decim(decim),
    .hold(hold), .force_trig(force_trig), .frame_done(frame_done),
    .rd_addr(rd_addr), .rd_sign(rd_sign), .rd_mag(rd_mag),
    .frame_ready(frame_ready), .auto_trig(auto_trig), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendv(input int val);
    sample_sign  = (val < 0);
    sample_mag   = 7'(val < 0 ? -val : val);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_addr = 8'(a);
    tick();
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (state !== 2'b00) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
    total_cnt++; if (frame_ready !== 1'b0) $display("FAIL reset_frame_ready got=%b exp=0", frame_ready); else pass_cnt++;
    total_cnt++; if (auto_trig !== 1'b0) $display("FAIL reset_auto_trig got=%b exp=0", auto_trig); else pass_cnt++;
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h00) $display("FAIL reset_rd got=%h exp=00", {rd_sign, rd_mag}); else pass_cnt++;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    trig_level = 8'sd0; trig_slope = 1'b0; decim = 16'd0;
    for (int i = -3; i <= 0; i++) sendv(i);
    total_cnt++; if (state !== 2'b01) $display("FAIL ramp_trig_state got=%0d exp=1", state); else pass_cnt++;
    for (int i = 1; i <= 158; i++) sendv(i);
    total_cnt++; if (frame_ready !== 1'b0) $display("FAIL ramp_early_ready got=%b exp=0", frame_ready); else pass_cnt++;
    sendv(159);
    total_cnt++; if (frame_ready !== 1'b1) $display("FAIL ramp_ready got=%b exp=1", frame_ready); else pass_cnt++;
    total_cnt++; if (state !== 2'b10) $display("FAIL ramp_ready_state got=%0d exp=2", state); else pass_cnt++;
    total_cnt++; if (auto_trig !== 1'b0) $display("FAIL ramp_auto_trig got=%b exp=0", auto_trig); else pass_cnt++;
    rd(0);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h00) $display("FAIL ramp_buf0 got=%h exp=00", {rd_sign, rd_mag}); else pass_cnt++;
    rd(1);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h01) $display("FAIL ramp_buf1 got=%h exp=01", {rd_sign, rd_mag}); else pass_cnt++;
    rd(159);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h1f) $display("FAIL ramp_buf159 got=%h exp=1f", {rd_sign, rd_mag}); else pass_cnt++;
    pulse_done();
    total_cnt++; if ({state, frame_ready} !== 3'b000) $display("FAIL ramp_rearm got=%b exp=000", {state, frame_ready}); else pass_cnt++;
  endtask

  task automatic test_decim();
    decim = 16'd3;
    for (int j = 0; j < 640; j++) begin
      force_trig = (j == 0);
      sendv(j % 128);
      if (j == 635) begin
        total_cnt++; if (frame_ready !== 1'b0) $display("FAIL decim_early_ready got=%b exp=0", frame_ready); else pass_cnt++;
      end
      if (j == 636) begin
        total_cnt++; if (frame_ready !== 1'b1) $display("FAIL decim_ready got=%b exp=1", frame_ready); else pass_cnt++;
      end
    end
    force_trig = 1'b0;
    total_cnt++; if (state !== 2'b10) $display("FAIL decim_state got=%0d exp=2", state); else pass_cnt++;
    rd(1);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h04) $display("FAIL decim_buf1 got=%h exp=04", {rd_sign, rd_mag}); else pass_cnt++;
    rd(40);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h20) $display("FAIL decim_buf40 got=%h exp=20", {rd_sign, rd_mag}); else pass_cnt++;
    rd(159);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h7c) $display("FAIL decim_buf159 got=%h exp=7c", {rd_sign, rd_mag}); else pass_cnt++;
    pulse_done();
    total_cnt++; if (state !== 2'b00) $display("FAIL decim_rearm got=%0d exp=0", state); else pass_cnt++;
    decim = 16'd0;
  endtask

  task automatic test_auto();
    int errs;
    trig_level = 8'sd20;
    for (int i = 0; i < 7; i++) sendv(5);
    total_cnt++; if (state !== 2'b00) $display("FAIL auto_pre_state got=%0d exp=0", state); else pass_cnt++;
    sendv(5);
    total_cnt++; if (state !== 2'b01) $display("FAIL auto_trig_state got=%0d exp=1", state); else pass_cnt++;
    total_cnt++; if (auto_trig !== 1'b1) $display("FAIL auto_trig_flag got=%b exp=1", auto_trig); else pass_cnt++;
    for (int i = 0; i < 159; i++) sendv(5);
    errs = 0;
    for (int a = 0; a < 160; a++) begin
      rd(a);
      if ({rd_sign, rd_mag} !== 8'h05) errs++;
    end
    total_cnt++; if (errs !== 0) $display("FAIL auto_buffer bad_entries=%0d exp=0", errs); else pass_cnt++;
  endtask

  task automatic test_hold();
    hold = 1'b1;
    tick();
    total_cnt++; if (state !== 2'b10) $display("FAIL hold_ready_state got=%0d exp=2", state); else pass_cnt++;
    pulse_done();
    total_cnt++; if ({state, frame_ready} !== 3'b111) $display("FAIL hold_enter got=%b exp=111", {state, frame_ready}); else pass_cnt++;
    pulse_done();
    pulse_done();
    total_cnt++; if ({state, frame_ready} !== 3'b111) $display("FAIL hold_ignore_done got=%b exp=111", {state, frame_ready}); else pass_cnt++;
    hold = 1'b0;
    tick();
    total_cnt++; if ({state, frame_ready} !== 3'b000) $display("FAIL hold_release got=%b exp=000", {state, frame_ready}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    trig_level = 8'sd0;
    sendv(-5);
    force_trig = 1'b1;
    sendv(-5);
    force_trig = 1'b0;
    for (int i = 0; i < 79; i++) sendv(i);
    total_cnt++; if (state !== 2'b01) $display("FAIL rmid_capture got=%0d exp=1", state); else pass_cnt++;
    resetn = 1'b0;
    #1;
    total_cnt++; if ({state, frame_ready} !== 3'b000) $display("FAIL rmid_async got=%b exp=000", {state, frame_ready}); else pass_cnt++;
    #1 resetn = 1'b1;
    tick();
    sendv(5);
    total_cnt++; if (state !== 2'b00) $display("FAIL rmid_no_stale_prev got=%0d exp=0", state); else pass_cnt++;
    sendv(-1);
    sendv(1);
    total_cnt++; if (state !== 2'b01) $display("FAIL rmid_fresh_cross got=%0d exp=1", state); else pass_cnt++;
    resetn = 1'b0;
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic test_falling();
    trig_level = 8'sd3; trig_slope = 1'b1;
    sendv(5);
    total_cnt++; if (state !== 2'b00) $display("FAIL fall_pre got=%0d exp=0", state); else pass_cnt++;
    sendv(3);
    total_cnt++; if (state !== 2'b01) $display("FAIL fall_trig got=%0d exp=1", state); else pass_cnt++;
    rd(0);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h03) $display("FAIL fall_buf0 got=%h exp=03", {rd_sign, rd_mag}); else pass_cnt++;
    rd(200);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h00) $display("FAIL fall_oob got=%h exp=00", {rd_sign, rd_mag}); else pass_cnt++;
    for (int i = 0; i < 159; i++) sendv(-7);
    rd(1);
    total_cnt++; if ({rd_sign, rd_mag} !== 8'h87) $display("FAIL fall_neg got=%h exp=87", {rd_sign, rd_mag}); else pass_cnt++;
    hold = 1'b1;
    pulse_done();
    total_cnt++; if ({state, frame_ready} !== 3'b111) $display("FAIL fall_hold_same_cycle got=%b exp=111", {state, frame_ready}); else pass_cnt++;
    hold = 1'b0;
    tick();
    total_cnt++; if (state !== 2'b00) $display("FAIL fall_rearm got=%0d exp=0", state); else pass_cnt++;
  endtask

  initial begin
    resetn = 1'b0;
    sample_valid = 1'b0; sample_sign = 1'b0; sample_mag = '0;
    trig_level = '0; trig_slope = 1'b0; decim = '0;
    hold = 1'b0; force_trig = 1'b0; frame_done = 1'b0; rd_addr = '0;
    test_reset();
    test_ramp();
    test_decim();
    test_auto();
    test_hold();
    test_reset_mid();
    test_falling();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
